// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter: round-robin owner selection for a shared gated D latch
// bank, plus the setup / open / close gate sequence and a one-cycle ack.
module latch_write_arbiter #(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2   // 1..255 cycles of open gate per write
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   wdata,
  output logic [3:0]            gnt,
  output logic [DATA_W-1:0]     latch_d,
  output logic                  latch_en,
  output logic [3:0]            ack,
  output logic                  busy,
  output logic [1:0]            last_owner
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] OPEN  = 2'd2;
  localparam logic [1:0] CLOSE = 2'd3;

  localparam logic [7:0] CNT_LOAD = 8'(HOLD_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] ptr;
  logic [1:0] sel;
  logic [7:0] cnt;
  logic [1:0] pick;

  // First requesting index when scanning ptr, ptr+1, ... with 2-bit wrap.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] c;
    rr_pick = p;
    // Walk from the farthest offset down so the nearest set bit wins last.
    for (int k = 3; k >= 0; k--) begin
      c = p + 2'(k);
      if (r[c]) rr_pick = c;
    end
  endfunction

  // Arbitration result for the current request vector and pointer.
  always_comb begin
    pick = rr_pick(req, ptr);
  end

  // Transaction sequencer; every output is a flop so the latch sees clean edges.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: reset clears only control state and output flops; the latch bank
      // itself is outside this block and keeps whatever it last captured.
      state      <= IDLE;
      ptr        <= 2'd0;
      sel        <= 2'd0;
      cnt        <= 8'd0;
      gnt        <= 4'd0;
      latch_d    <= '0;
      latch_en   <= 1'b0;
      ack        <= 4'd0;
      busy       <= 1'b0;
      last_owner <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 4'd0) begin
            sel     <= pick;
            gnt     <= 4'(1) << pick;
            latch_d <= wdata[pick*DATA_W +: DATA_W];
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          // D has been stable for a full cycle; open the gate.
          latch_en <= 1'b1;
          cnt      <= CNT_LOAD;
          state    <= OPEN;
        end
        OPEN: begin
          if (cnt == 8'd0) begin
            latch_en <= 1'b0;
            ack      <= 4'(1) << sel;
            state    <= CLOSE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CLOSE: begin
          // Hold cycle: latch_d unchanged after the gate falls.
          ack        <= 4'd0;
          gnt        <= 4'd0;
          busy       <= 1'b0;
          last_owner <= sel;
          ptr        <= sel + 2'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed bench for latch_write_arbiter with HOLD_CYCLES=2.
module tb_latch_write_arbiter;

  localparam int DATA_W = 8;

  logic                clock;
  logic                reset;
  logic [3:0]          req;
  logic [4*DATA_W-1:0] wdata;
  logic [3:0]          gnt;
  logic [DATA_W-1:0]   latch_d;
  logic                latch_en;
  logic [3:0]          ack;
  logic                busy;
  logic [1:0]          last_owner;

  int n_checks = 0;
  int n_fail   = 0;

  latch_write_arbiter #(.DATA_W(DATA_W), .HOLD_CYCLES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .wdata      (wdata),
    .gnt        (gnt),
    .latch_d    (latch_d),
    .latch_en   (latch_en),
    .ack        (ack),
    .busy       (busy),
    .last_owner (last_owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and sample 1 ns later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " gnt"},      32'(gnt), 32'h0);
    check({tag, " busy"},     32'(busy), 32'h0);
    check({tag, " latch_en"}, 32'(latch_en), 32'h0);
    check({tag, " ack"},      32'(ack), 32'h0);
  endtask

  // One full transaction from IDLE; req already presented. Applies req_after
  // once ack is seen (during the hold cycle).
  task automatic do_txn(input string tag, input int idx, input logic [7:0] d,
                        input logic [3:0] req_after);
    logic [3:0] oh;
    oh = 4'(1) << idx;
    step(); // edge 0
    check({tag, " gnt@0"},      32'(gnt), 32'(oh));
    check({tag, " latch_d@0"},  32'(latch_d), 32'(d));
    check({tag, " busy@0"},     32'(busy), 32'h1);
    check({tag, " latch_en@0"}, 32'(latch_en), 32'h0);
    step(); // edge 1
    check({tag, " latch_en@1"}, 32'(latch_en), 32'h1);
    check({tag, " ack@1"},      32'(ack), 32'h0);
    step(); // edge 2
    check({tag, " latch_en@2"}, 32'(latch_en), 32'h1);
    check({tag, " ack@2"},      32'(ack), 32'h0);
    step(); // edge 3
    check({tag, " latch_en@3"}, 32'(latch_en), 32'h0);
    check({tag, " ack@3"},      32'(ack), 32'(oh));
    check({tag, " latch_d@3"},  32'(latch_d), 32'(d));
    req = req_after;
    step(); // edge 4
    check_idle({tag, " @4"});
    check({tag, " last_owner"}, 32'(last_owner), 32'(idx));
  endtask

  initial begin
    // Reset with random inputs; nothing may be granted.
    reset = 1'b1;
    req   = 4'($urandom);
    wdata = {$urandom};
    #3;
    for (int i = 0; i < 3; i++) begin
      step();
      req   = 4'($urandom);
      wdata = {$urandom};
    end
    check_idle("reset");
    check("reset latch_d",    32'(latch_d), 32'h0);
    check("reset last_owner", 32'(last_owner), 32'h0);

    // Single write from requester 1.
    req   = 4'b0000;
    wdata = 32'h0000_A500;
    reset = 1'b0;
    req   = 4'b0010;
    do_txn("single", 1, 8'hA5, 4'b0000);

    // Fairness from a fresh pointer: 0,1,2,3,0 with req held at 1111.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    wdata = 32'h4433_2211;
    req   = 4'b1111;
    do_txn("fair0", 0, 8'h11, 4'b1111);
    do_txn("fair1", 1, 8'h22, 4'b1111);
    do_txn("fair2", 2, 8'h33, 4'b1111);
    do_txn("fair3", 3, 8'h44, 4'b1111);
    do_txn("fair4", 0, 8'h11, 4'b0000);

    // Rotation: ptr=1 now. Grant 2, then 1100 -> 3 then 2, then wrap to 0.
    wdata = 32'hD4C3_B2A1;
    req   = 4'b0100;
    do_txn("rot2",  2, 8'hC3, 4'b1100);
    do_txn("rot3",  3, 8'hD4, 4'b1100);
    do_txn("rot2b", 2, 8'hC3, 4'b0001);
    do_txn("wrap0", 0, 8'hA1, 4'b0000);

    // Data stability: ptr=1. Owner's data churns and req drops mid-write.
    wdata = 32'h0000_5A00;
    req   = 4'b0010;
    step();
    check("stab gnt",  32'(gnt), 32'h2);
    check("stab d@0",  32'(latch_d), 32'h5A);
    for (int e = 1; e <= 4; e++) begin
      wdata[15:8] = 8'(e * 37 + 3);
      if (e == 2) req = 4'b0000;
      step();
      check($sformatf("stab d@%0d", e), 32'(latch_d), 32'h5A);
      if (e == 3) check("stab ack", 32'(ack), 32'h2);
    end
    check_idle("stab end");
    check("stab last_owner", 32'(last_owner), 32'h1);

    // Reset mid-write: ptr=2, grant 2, abort while the gate is open.
    wdata = 32'h77_66_55_44;
    req   = 4'b0100;
    step();
    check("abort gnt", 32'(gnt), 32'h4);
    step();
    check("abort latch_en before", 32'(latch_en), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_idle("abort async");
    check("abort latch_d", 32'(latch_d), 32'h0);
    step();
    check("abort no ack", 32'(ack), 32'h0);
    check("abort gnt held", 32'(gnt), 32'h0);
    reset = 1'b0;
    req   = 4'b1000;
    do_txn("post", 3, 8'h77, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
